// File: rtl/mnist_proto_pkg.sv
// Shared constants, state encoding and helpers for the
// framed MNIST UART request/response protocol.
package mnist_proto_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RECV,
      S_CHK,
      S_WAIT,
      S_SEND
   } state_t;

   localparam logic [7:0] ST_OK       = 8'h00;
   localparam logic [7:0] ST_BADSUM   = 8'h01;
   localparam logic [7:0] ST_TIMEOUT  = 8'h02;
   localparam logic [7:0] CLS_INVALID = 8'hFF;
   localparam logic [7:0] DEF_REQ_HDR = 8'hAA;
   localparam logic [7:0] DEF_RSP_HDR = 8'h55;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/mnist_rsp_sender.sv
// Paced response transmitter: emits up to three loaded bytes,
// one tx_flag strobe every BYTE_GAP_CYC cycles.
module mnist_rsp_sender #(
   parameter int BYTE_GAP_CYC = 4600
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] b0,
   input  logic [7:0] b1,
   input  logic [7:0] b2,
   input  logic [1:0] len,
   output logic [7:0] tx_data,
   output logic       tx_flag,
   output logic       done
);

   localparam logic [31:0] GAP_RLD = 32'(BYTE_GAP_CYC - 1);

   logic [7:0]  b1_q;
   logic [7:0]  b2_q;
   logic [1:0]  len_q;
   logic [1:0]  idx;
   logic [31:0] gap;
   logic        active;

   // done fires on the last cycle of the trailing gap
   assign done = active && (gap == '0) && (idx == len_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_data <= '0;
         tx_flag <= 1'b0;
         b1_q    <= '0;
         b2_q    <= '0;
         len_q   <= '0;
         idx     <= '0;
         gap     <= '0;
         active  <= 1'b0;
      end else begin
         tx_flag <= 1'b0;
         if (load) begin
            tx_data <= b0;
            tx_flag <= 1'b1;
            b1_q    <= b1;
            b2_q    <= b2;
            len_q   <= len;
            idx     <= 2'd1;
            gap     <= GAP_RLD;
            active  <= 1'b1;
         end else if (active) begin
            if (gap == '0) begin
               if (idx == len_q) begin
                  active <= 1'b0;
               end else begin
                  tx_flag <= 1'b1;
                  idx     <= idx + 2'd1;
                  gap     <= GAP_RLD;
               end
            end else begin
               gap <= gap - 32'd1;
               // present the next byte one cycle ahead of its strobe
               if (gap == 32'd1 && idx != len_q)
                  tx_data <= (idx == 2'd1) ? b1_q : b2_q;
            end
         end
      end
   end

endmodule

// File: rtl/mnist_uart_frame_ctrl.sv
// Framed request/response controller between the UART and the
// MNIST core: validates pixel frames and returns a paced result.
module mnist_uart_frame_ctrl
   import mnist_proto_pkg::*;
#(
   parameter int          IMG_PIXELS      = 784,
   parameter int          RAW_MODE        = 0,
   parameter logic [7:0]  REQ_HDR         = DEF_REQ_HDR,
   parameter logic [7:0]  RSP_HDR         = DEF_RSP_HDR,
   parameter int          RX_TIMEOUT_CYC  = 5_000_000,
   parameter int          RES_TIMEOUT_CYC = 50_000_000,
   parameter int          BYTE_GAP_CYC    = 4600
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_flag,
   output logic [7:0] pix_data,
   output logic       pix_valid,
   output logic       core_start,
   input  logic [3:0] result,
   input  logic       result_valid,
   output logic [7:0] tx_data,
   output logic       tx_flag,
   output logic [3:0] disp_num,
   output logic       busy,
   output logic [7:0] err_cnt
);

   localparam logic [15:0] LAST_PIX = 16'(IMG_PIXELS - 1);
   localparam logic [31:0] RX_RLD   = 32'(RX_TIMEOUT_CYC - 1);
   localparam logic [31:0] RES_RLD  = 32'(RES_TIMEOUT_CYC - 1);
   localparam bit          RAW      = (RAW_MODE != 0);

   state_t      state;
   logic [15:0] pix_cnt;
   logic [7:0]  sum;
   logic [31:0] tmo;
   logic        match;
   logic        res_hit;
   logic        res_tmo;
   logic        good;
   logic        load;
   logic        done;
   logic [7:0]  cls;
   logic [7:0]  status;

   assign busy    = (state != S_IDLE);
   assign res_hit = (state == S_WAIT) && result_valid;
   assign res_tmo = (state == S_WAIT) && !result_valid && (tmo == '0);
   assign load    = res_hit || res_tmo;
   assign good    = res_hit && (RAW || match);
   assign cls     = good ? {4'h0, result} : CLS_INVALID;
   assign status  = res_tmo ? ST_TIMEOUT : (good ? ST_OK : ST_BADSUM);

   mnist_rsp_sender #(
      .BYTE_GAP_CYC(BYTE_GAP_CYC)
   ) u_sender (
      .clk    (sys_clk),
      .rst_n  (sys_rst_n),
      .load   (load),
      .b0     (RAW ? cls : RSP_HDR),
      .b1     (cls),
      .b2     (status),
      .len    (RAW ? 2'd1 : 2'd3),
      .tx_data(tx_data),
      .tx_flag(tx_flag),
      .done   (done)
   );

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state      <= S_IDLE;
         pix_cnt    <= '0;
         sum        <= '0;
         tmo        <= '0;
         match      <= 1'b0;
         pix_data   <= '0;
         pix_valid  <= 1'b0;
         core_start <= 1'b0;
         disp_num   <= '0;
         err_cnt    <= '0;
      end else begin
         pix_valid  <= 1'b0;
         core_start <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (rx_flag && (RAW || rx_data == REQ_HDR)) begin
                  core_start <= 1'b1;
                  sum        <= '0;
                  pix_cnt    <= '0;
                  tmo        <= RX_RLD;
                  state      <= S_RECV;
                  // legacy mode: the opening byte is already pixel 0
                  if (RAW) begin
                     pix_valid <= 1'b1;
                     pix_data  <= rx_data;
                     pix_cnt   <= 16'd1;
                     if (LAST_PIX == '0) begin
                        state <= S_WAIT;
                        tmo   <= RES_RLD;
                     end
                  end
               end
            end
            S_RECV: begin
               if (rx_flag) begin
                  pix_valid <= 1'b1;
                  pix_data  <= rx_data;
                  sum       <= sum + rx_data;
                  pix_cnt   <= pix_cnt + 16'd1;
                  tmo       <= RX_RLD;
                  if (pix_cnt == LAST_PIX) begin
                     if (RAW) begin
                        state <= S_WAIT;
                        tmo   <= RES_RLD;
                     end else begin
                        state <= S_CHK;
                     end
                  end
               end else if (tmo == '0) begin
                  state   <= S_IDLE;
                  err_cnt <= sat_inc(err_cnt);
               end else begin
                  tmo <= tmo - 32'd1;
               end
            end
            S_CHK: begin
               if (rx_flag) begin
                  match <= (rx_data == sum);
                  state <= S_WAIT;
                  tmo   <= RES_RLD;
               end else if (tmo == '0) begin
                  state   <= S_IDLE;
                  err_cnt <= sat_inc(err_cnt);
               end else begin
                  tmo <= tmo - 32'd1;
               end
            end
            S_WAIT: begin
               if (load) begin
                  state <= S_SEND;
                  if (good)
                     disp_num <= result;
                  else
                     err_cnt <= sat_inc(err_cnt);
               end else begin
                  tmo <= tmo - 32'd1;
               end
            end
            S_SEND: begin
               if (done)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mnist_uart_frame_ctrl.sv
// Directed-random bench for the framed MNIST UART controller,
// covering framed and legacy instances against a frame-level model.
module tb_mnist_uart_frame_ctrl;

   localparam int NP  = 4;
   localparam int GAP = 20;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_data = '0;
   logic       rx_flag = 1'b0;
   logic [3:0] result = '0;
   logic       result_valid = 1'b0;
   logic [7:0] rx_data_r = '0;
   logic       rx_flag_r = 1'b0;
   logic [3:0] result_r = '0;
   logic       result_valid_r = 1'b0;

   logic [7:0] pix_data, tx_data, err_cnt;
   logic       pix_valid, core_start, tx_flag, busy;
   logic [3:0] disp_num;
   logic [7:0] pix_data_r, tx_data_r, err_cnt_r;
   logic       pix_valid_r, core_start_r, tx_flag_r, busy_r;
   logic [3:0] disp_num_r;

   mnist_uart_frame_ctrl #(
      .IMG_PIXELS(NP), .RAW_MODE(0),
      .RX_TIMEOUT_CYC(100), .RES_TIMEOUT_CYC(200), .BYTE_GAP_CYC(GAP)
   ) dut (
      .sys_clk(clk), .sys_rst_n(rst_n),
      .rx_data(rx_data), .rx_flag(rx_flag),
      .pix_data(pix_data), .pix_valid(pix_valid), .core_start(core_start),
      .result(result), .result_valid(result_valid),
      .tx_data(tx_data), .tx_flag(tx_flag), .disp_num(disp_num),
      .busy(busy), .err_cnt(err_cnt)
   );

   mnist_uart_frame_ctrl #(
      .IMG_PIXELS(NP), .RAW_MODE(1),
      .RX_TIMEOUT_CYC(100), .RES_TIMEOUT_CYC(200), .BYTE_GAP_CYC(GAP)
   ) dut_raw (
      .sys_clk(clk), .sys_rst_n(rst_n),
      .rx_data(rx_data_r), .rx_flag(rx_flag_r),
      .pix_data(pix_data_r), .pix_valid(pix_valid_r),
      .core_start(core_start_r),
      .result(result_r), .result_valid(result_valid_r),
      .tx_data(tx_data_r), .tx_flag(tx_flag_r), .disp_num(disp_num_r),
      .busy(busy_r), .err_cnt(err_cnt_r)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] pq[$], tq[$], pq_r[$], tq_r[$];
   int         tt[$], tt_r[$];
   int         starts = 0, starts_r = 0, rv_cyc = 0;
   logic [7:0] px[NP];
   logic [3:0] disp_exp = '0, disp_exp_r = '0;
   int         err_exp = 0, err_exp_r = 0;

   always @(negedge clk) begin
      if (pix_valid) pq.push_back(pix_data);
      if (pix_valid_r) pq_r.push_back(pix_data_r);
      if (core_start) starts++;
      if (core_start_r) starts_r++;
      if (tx_flag) begin
         tq.push_back(tx_data);
         tt.push_back(cyc);
      end
      if (tx_flag_r) begin
         tq_r.push_back(tx_data_r);
         tt_r.push_back(cyc);
      end
      if (result_valid || result_valid_r) rv_cyc = cyc;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear();
      pq.delete(); tq.delete(); tt.delete();
      pq_r.delete(); tq_r.delete(); tt_r.delete();
      starts = 0;
      starts_r = 0;
   endtask

   task automatic send_byte(input bit raw, input logic [7:0] b);
      if (raw) begin
         rx_data_r = b;
         rx_flag_r = 1'b1;
      end else begin
         rx_data = b;
         rx_flag = 1'b1;
      end
      tick(1);
      rx_flag = 1'b0;
      rx_flag_r = 1'b0;
      tick($urandom_range(0, 3));
   endtask

   task automatic send_res(input bit raw, input logic [3:0] r);
      if (raw) begin
         result_r = r;
         result_valid_r = 1'b1;
      end else begin
         result = r;
         result_valid = 1'b1;
      end
      tick(1);
      result_valid = 1'b0;
      result_valid_r = 1'b0;
   endtask

   task automatic wait_idle(input bit raw, input int lim);
      int n = 0;
      while ((raw ? busy_r : busy) && n < lim) begin
         tick(1);
         n++;
      end
      chk("idle_bound", 32'(raw ? busy_r : busy), 0);
      tick(2);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_pix_data"}, 32'(pix_data), 0);
      chk({tag, "_pix_valid"}, 32'(pix_valid), 0);
      chk({tag, "_core_start"}, 32'(core_start), 0);
      chk({tag, "_tx_data"}, 32'(tx_data), 0);
      chk({tag, "_tx_flag"}, 32'(tx_flag), 0);
      chk({tag, "_disp"}, 32'(disp_num), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_err"}, 32'(err_cnt), 0);
      chk({tag, "_raw_busy"}, 32'(busy_r), 0);
   endtask

   // One request frame plus the model's view of what must come back.
   task automatic run_frame(input string tag, input bit raw,
                            input logic [7:0] ck_delta,
                            input bit give_res, input bit hdr_in);
      logic [3:0] r;
      logic       ok;
      logic [7:0] cls, st;
      logic [7:0] q[$], ex[$];
      int         t[$];
      int         s = 0;
      clear();
      for (int i = 0; i < NP; i++) px[i] = 8'($urandom_range(0, 255));
      if (hdr_in) px[1] = 8'hAA;
      for (int i = 0; i < NP; i++) s += int'(px[i]);
      if (!raw) send_byte(1'b0, 8'hAA);
      for (int i = 0; i < NP; i++) send_byte(raw, px[i]);
      if (!raw) send_byte(1'b0, 8'(s % 256) + ck_delta);
      r = 4'($urandom_range(0, 9));
      tick($urandom_range(1, 5));
      if (give_res) begin
         send_res(raw, r);
         if (!raw) begin
            tick(3);
            send_byte(1'b0, 8'($urandom));
         end
      end
      wait_idle(raw, 600);

      ok  = give_res && (raw || ck_delta == 8'd0);
      cls = ok ? {4'h0, r} : 8'hFF;
      st  = !give_res ? 8'h02 : (ok ? 8'h00 : 8'h01);
      if (raw) begin
         if (ok) disp_exp_r = r;
         else err_exp_r++;
         ex.push_back(cls);
         q = pq_r;
      end else begin
         if (ok) disp_exp = r;
         else err_exp++;
         ex.push_back(8'h55);
         ex.push_back(cls);
         ex.push_back(st);
         q = pq;
      end

      chk({tag, "_starts"}, 32'(raw ? starts_r : starts), 1);
      chk({tag, "_npix"}, 32'(q.size()), NP);
      for (int i = 0; i < q.size() && i < NP; i++)
         chk({tag, "_pix"}, 32'(q[i]), 32'(px[i]));

      if (raw) begin
         q = tq_r;
         t = tt_r;
      end else begin
         q = tq;
         t = tt;
      end
      chk({tag, "_ntx"}, 32'(q.size()), 32'(ex.size()));
      for (int i = 0; i < q.size() && i < ex.size(); i++)
         chk({tag, "_txbyte"}, 32'(q[i]), 32'(ex[i]));
      for (int i = 1; i < t.size(); i++)
         chk({tag, "_txgap"}, 32'(t[i] - t[i-1]), GAP);
      if (give_res && t.size() > 0)
         chk({tag, "_tx_lat"}, 32'(t[0]), 32'(rv_cyc + 1));
      chk({tag, "_disp"}, 32'(raw ? disp_num_r : disp_num),
          32'(raw ? disp_exp_r : disp_exp));
      chk({tag, "_err"}, 32'(raw ? err_cnt_r : err_cnt),
          32'(raw ? err_exp_r : err_exp));
   endtask

   initial begin
      rst_n = 1'b0;
      #12;
      chk_reset("reset");
      tick(1);
      rst_n = 1'b1;
      tick(2);

      run_frame("good", 1'b0, 8'd0, 1'b1, 1'b0);
      run_frame("good_hdr_data", 1'b0, 8'd0, 1'b1, 1'b1);
      run_frame("badsum", 1'b0, 8'($urandom_range(1, 255)), 1'b1, 1'b0);

      // header plus one pixel, then silence past the idle limit
      clear();
      send_byte(1'b0, 8'hAA);
      send_byte(1'b0, 8'($urandom));
      tick(110);
      err_exp++;
      chk("rxtmo_busy", 32'(busy), 0);
      chk("rxtmo_ntx", 32'(tq.size()), 0);
      chk("rxtmo_err", 32'(err_cnt), 32'(err_exp));
      chk("rxtmo_disp", 32'(disp_num), 32'(disp_exp));

      run_frame("after_rxtmo", 1'b0, 8'd0, 1'b1, 1'b0);
      run_frame("res_tmo", 1'b0, 8'd0, 1'b0, 1'b0);

      // a result strobe while idle must not touch the display
      send_res(1'b0, 4'hE);
      tick(2);
      chk("stray_res_disp", 32'(disp_num), 32'(disp_exp));
      chk("stray_res_busy", 32'(busy), 0);

      run_frame("raw", 1'b1, 8'd0, 1'b1, 1'b0);

      // reset in the middle of a frame
      clear();
      send_byte(1'b0, 8'hAA);
      send_byte(1'b0, 8'($urandom));
      chk("midrst_in_recv", 32'(busy), 1);
      rst_n = 1'b0;
      #2;
      chk_reset("midrst");
      tick(2);
      rst_n = 1'b1;
      disp_exp = '0;
      disp_exp_r = '0;
      err_exp = 0;
      err_exp_r = 0;
      tick(1);
      chk("midrst_ntx", 32'(tq.size()), 0);
      run_frame("post_rst", 1'b0, 8'd0, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
